selectors: RTL and testbench

SELECTORS -- requirements
Module: selectors

---
 rtl/selectors_pkg.sv | 14 +
 rtl/selectors_dec.sv | 22 ++
 rtl/selectors.sv | 57 +++++
 tb/tb_selectors.sv | 126 ++++++++++++
 4 files changed

// File: rtl/selectors_pkg.sv
// Shared constants and helpers for the selectors block.
//   N_IN_DEF  : default number of data inputs
//   SEL_W_DEF : default select width (N_IN_DEF == 2**SEL_W_DEF)
package selectors_pkg;

    localparam int unsigned N_IN_DEF  = 8;
    localparam int unsigned SEL_W_DEF = 3;

    // True when the input count exactly fills the select space.
    function automatic bit cfg_ok(input int unsigned n_in, input int unsigned sel_w);
        return n_in == (32'd1 << sel_w);
    endfunction

endpackage : selectors_pkg

// File: rtl/selectors_dec.sv
// One-hot decoder: drives exactly bit A of sel_oh high.
//   A      : input,  SEL_W - unsigned select index
//   sel_oh : output, N_IN  - combinational one-hot decode of A
module selectors_dec
    import selectors_pkg::*;
#(
    parameter int unsigned N_IN  = N_IN_DEF,
    parameter int unsigned SEL_W = SEL_W_DEF
) (
    input  logic [SEL_W-1:0] A,
    output logic [N_IN-1:0]  sel_oh
);

    // Compare against every index so each output bit is an independent match.
    always_comb begin
        sel_oh = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            sel_oh[i] = (A == SEL_W'(i));
        end
    end

endmodule : selectors_dec

// File: rtl/selectors.sv
// Bit selector with a registered copy of the selected bit.
//   clk     : input,  1     - rising-edge clock
//   rst     : input,  1     - synchronous active-high reset (registered outputs only)
//   B       : input,  N_IN  - candidate bits
//   A       : input,  SEL_W - select index
//   en      : input,  1     - load enable for res_q/valid_q
//   res     : output, 1     - combinational B[A]
//   sel_oh  : output, N_IN  - combinational one-hot decode of A
//   res_q   : output, 1     - registered res
//   valid_q : output, 1     - res_q holds a captured value
module selectors
    import selectors_pkg::*;
#(
    parameter int unsigned N_IN  = N_IN_DEF,
    parameter int unsigned SEL_W = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  B,
    input  logic [SEL_W-1:0] A,
    input  logic             en,
    output logic             res,
    output logic [N_IN-1:0]  sel_oh,
    output logic             res_q,
    output logic             valid_q
);

    // Reject parameter sets where the select space and input count disagree.
    generate
        if (!cfg_ok(N_IN, SEL_W)) begin : g_bad_cfg
            $error("selectors: N_IN must equal 2**SEL_W");
        end
    endgenerate

    selectors_dec #(
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_dec (
        .A      (A),
        .sel_oh (sel_oh)
    );

    // The one-hot decode is the only select path into res.
    assign res = |(sel_oh & B);

    // Capture register; reset wins over en and discards any held value.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (en) begin
            res_q   <= res;
            valid_q <= 1'b1;
        end
    end

endmodule : selectors

// File: tb/tb_selectors.sv
// Directed self-checking bench for selectors.
module tb_selectors;

    logic       clk;
    logic       rst;
    logic [7:0] B;
    logic [2:0] A;
    logic       en;
    logic       res;
    logic [7:0] sel_oh;
    logic       res_q;
    logic       valid_q;

    int n_cmp;
    int n_err;

    selectors #(.N_IN(8), .SEL_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .B       (B),
        .A       (A),
        .en      (en),
        .res     (res),
        .sel_oh  (sel_oh),
        .res_q   (res_q),
        .valid_q (valid_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pat_3c;
        logic [7:0] exp_oh;
        n_cmp  = 0;
        n_err  = 0;
        pat_3c = 8'b0011_1100;

        rst = 1'b1; en = 1'b0; B = 8'h00; A = 3'd0;
        tick();
        tick();
        chk("rst_res_q",   8'(res_q),   8'h00);
        chk("rst_valid_q", 8'(valid_q), 8'h00);

        rst = 1'b0;
        tick();
        chk("idle_valid_q", 8'(valid_q), 8'h00);

        // Basic select
        B = 8'hFE; A = 3'd0; #1;
        chk("fe_a0_res", 8'(res), 8'h00);
        chk("fe_a0_oh",  sel_oh,  8'h01);
        A = 3'd1; #1;
        chk("fe_a1_res", 8'(res), 8'h01);
        chk("fe_a1_oh",  sel_oh,  8'h02);

        // Walking one across every select value
        for (int k = 0; k < 8; k++) begin
            for (int a = 0; a < 8; a++) begin
                B = 8'h01 << k;
                A = 3'(a);
                exp_oh = 8'h01 << a;
                #1;
                chk("walk_res", 8'(res), (a == k) ? 8'h01 : 8'h00);
                chk("walk_oh",  sel_oh,  exp_oh);
            end
        end

        // Capture and hold
        B = 8'hA5; A = 3'd7; en = 1'b1;
        tick();
        chk("cap_res_q",   8'(res_q),   8'h01);
        chk("cap_valid_q", 8'(valid_q), 8'h01);
        A = 3'd1; en = 1'b0; #1;
        chk("hold_res", 8'(res), 8'h00);
        tick();
        chk("hold_res_q",   8'(res_q),   8'h01);
        chk("hold_valid_q", 8'(valid_q), 8'h01);

        // Reset beats enable, then recapture
        A = 3'd7; rst = 1'b1; en = 1'b1; #1;
        chk("pre_rst_res", 8'(res), 8'h01);
        tick();
        chk("rst_en_res_q",   8'(res_q),   8'h00);
        chk("rst_en_valid_q", 8'(valid_q), 8'h00);
        chk("rst_en_res",     8'(res),     8'h01);
        rst = 1'b0;
        tick();
        chk("recap_res_q",   8'(res_q),   8'h01);
        chk("recap_valid_q", 8'(valid_q), 8'h01);

        // Combinational path stays live under reset
        rst = 1'b1; en = 1'b1; B = 8'h3C;
        for (int a = 0; a < 8; a++) begin
            A = 3'(a);
            tick();
            chk("rst_sweep_res",   8'(res),     8'(pat_3c[a]));
            chk("rst_sweep_res_q", 8'(res_q),   8'h00);
            chk("rst_sweep_valid", 8'(valid_q), 8'h00);
        end

        // Capture a zero after reset
        rst = 1'b0; A = 3'd0;
        tick();
        chk("zero_res_q",   8'(res_q),   8'h00);
        chk("zero_valid_q", 8'(valid_q), 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_selectors
